// File: rtl/serial_pkg.sv
// Definitions shared by both ends of the keyboard serial link: the default message
// width, the frame-sequencer state encoding and the counter-width helper.
package serial_pkg;

    localparam int DEFAULT_MSG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } serial_state_t;

    // Width of a down/up counter covering 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_msg_fifo.sv
// Synchronous message queue; dout shows the head entry whenever empty is low.
module serial_msg_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Requests against a full or empty queue are dropped here, so callers need no gating.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/serial_out.sv
// Keyboard-message transmitter: queues messages and sends each one as a KBinit
// strobe followed by MSG_W data bits, MSB first, on serialOut.
module serial_out
    import serial_pkg::*;
#(
    parameter int MSG_W      = DEFAULT_MSG_W,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MSG_W-1:0] msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic             KBinit,
    output logic             serialOut,
    output logic             busy,
    output logic             status_send
);

    localparam int CW = cnt_width(MSG_W);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [CW-1:0] LAST_BIT = CW'(MSG_W - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);

    serial_state_t    state;
    serial_state_t    state_n;
    logic [MSG_W-1:0] shift_reg;
    logic [MSG_W-1:0] shift_n;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_n;
    logic [GW-1:0]    gap_cnt;
    logic [GW-1:0]    gap_cnt_n;
    logic             kbinit_n;
    logic             serial_n;
    logic             busy_n;
    logic             status_n;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [MSG_W-1:0] fifo_dout;

    serial_msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (msg_valid),
        .pop   (fifo_pop),
        .din   (msg_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // full is decoded from the FIFO's count register, so ready never depends on msg_valid.
    assign msg_ready = !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            KBinit      <= 1'b0;
            serialOut   <= 1'b0;
            busy        <= 1'b0;
            status_send <= 1'b0;
        end else begin
            state       <= state_n;
            shift_reg   <= shift_n;
            bit_cnt     <= bit_cnt_n;
            gap_cnt     <= gap_cnt_n;
            KBinit      <= kbinit_n;
            serialOut   <= serial_n;
            busy        <= busy_n;
            status_send <= status_n;
        end
    end

    // Output values are computed for the state being entered, so every output is a flop
    // that lines up exactly with the state it describes.
    always_comb begin
        state_n   = state;
        shift_n   = shift_reg;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        fifo_pop  = 1'b0;
        kbinit_n  = 1'b0;
        serial_n  = 1'b0;
        busy_n    = 1'b1;
        status_n  = 1'b0;

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_n   = fifo_dout;
                    bit_cnt_n = LAST_BIT;
                    state_n   = INIT;
                    kbinit_n  = 1'b1;
                    busy_n    = 1'b1;
                end
            end
            INIT: begin
                state_n  = SHIFT;
                serial_n = shift_reg[bit_cnt];
            end
            SHIFT: begin
                if (bit_cnt == '0) begin
                    state_n   = GAP;
                    gap_cnt_n = '0;
                    status_n  = (GAP_CYCLES == 1);
                end else begin
                    bit_cnt_n = bit_cnt - CW'(1);
                    serial_n  = shift_reg[bit_cnt_n];
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                    status_n  = (gap_cnt_n == LAST_GAP);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_out.sv
// Scoreboard bench for serial_out: a receiver model decodes frames at negedge and
// compares them against messages queued when they were pushed.
module tb_serial_out;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] msg_in = 4'h0;
    logic       msg_valid = 1'b0;
    logic       msg_ready, KBinit, serialOut, busy, status_send;

    logic [3:0] msg_in3 = 4'h0;
    logic       msg_valid3 = 1'b0;
    logic       msg_ready3, kb3, so3, busy3, st3;

    int checks = 0;
    int passes = 0;

    logic [3:0] exp_q[$];
    int         kb_times[$];
    int         cyc = 0;
    bit         mon_on = 1'b0;
    logic       prev_kb = 1'b0;
    bit         rx_active = 1'b0;
    bit         gap_chk = 1'b0;
    int         rx_cnt = 0;
    logic [3:0] rx_sr = 4'h0;
    logic [3:0] sb_exp;
    int         frames_rx = 0;
    int         kb_cnt = 0;
    int         st_cnt = 0;

    serial_out #(.MSG_W(4), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .msg_in(msg_in), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .KBinit(KBinit), .serialOut(serialOut),
        .busy(busy), .status_send(status_send)
    );

    serial_out #(.MSG_W(4), .FIFO_DEPTH(4), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .msg_in(msg_in3), .msg_valid(msg_valid3),
        .msg_ready(msg_ready3), .KBinit(kb3), .serialOut(so3),
        .busy(busy3), .status_send(st3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: KBinit starts a frame, the next four cycles carry the bits MSB first.
    always @(negedge clk) begin
        if (!mon_on) begin
            rx_active = 1'b0;
            gap_chk   = 1'b0;
        end else begin
            if (KBinit) begin
                checks++;
                if (prev_kb !== 1'b0) $display("[TB] FAIL kbinit_adjacent: got %b, want 0 before strobe", prev_kb);
                else passes++;
                checks++;
                if (busy !== 1'b1) $display("[TB] FAIL busy_in_init: got %b, want 1", busy);
                else passes++;
            end
            checks++;
            if (int'(dut.u_fifo.count) > 4) $display("[TB] FAIL fifo_occupancy: got %0d, want <= 4", dut.u_fifo.count);
            else passes++;
            if (status_send) st_cnt++;
            if (gap_chk) begin
                gap_chk = 1'b0;
                checks++;
                if (serialOut !== 1'b0) $display("[TB] FAIL gap_bit: got %b, want 0", serialOut);
                else passes++;
                checks++;
                if (status_send !== 1'b1) $display("[TB] FAIL status_in_gap: got %b, want 1", status_send);
                else passes++;
            end
            if (rx_active) begin
                rx_sr = {rx_sr[2:0], serialOut};
                rx_cnt++;
                if (rx_cnt == 4) begin
                    rx_active = 1'b0;
                    gap_chk   = 1'b1;
                    frames_rx++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("[TB] FAIL frame_unexpected: got %h, want no frame", rx_sr);
                    end else begin
                        sb_exp = exp_q.pop_front();
                        if (rx_sr !== sb_exp) $display("[TB] FAIL frame_data: got %h, want %h", rx_sr, sb_exp);
                        else passes++;
                    end
                end
            end
            if (KBinit) begin
                kb_times.push_back(cyc);
                kb_cnt++;
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end
        prev_kb = KBinit;
    end

    // Called at a negedge; holds the message until the DUT is ready, then queues the expectation.
    task automatic push_msg(input logic [3:0] d, output int waited);
        waited    = 0;
        msg_in    = d;
        msg_valid = 1'b1;
        while (!msg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!msg_ready) begin
            $display("[TB] FAIL push_timeout: got ready %b, want 1", msg_ready);
        end else begin
            passes++;
            exp_q.push_back(d);
            @(negedge clk);
        end
        msg_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int n = 0;
        while (frames_rx < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        ok = (frames_rx >= target);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        msg_valid  = 1'b0;
        msg_valid3 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (KBinit !== 1'b0) $display("[TB] FAIL reset_kbinit: got %b, want 0", KBinit); else passes++;
        checks++; if (serialOut !== 1'b0) $display("[TB] FAIL reset_serial: got %b, want 0", serialOut); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, want 0", busy); else passes++;
        checks++; if (status_send !== 1'b0) $display("[TB] FAIL reset_status: got %b, want 0", status_send); else passes++;
        checks++; if (msg_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b, want 1", msg_ready); else passes++;
        checks++; if (msg_ready3 !== 1'b1 || busy3 !== 1'b0) $display("[TB] FAIL reset_gap3: got ready %b busy %b, want 1 0", msg_ready3, busy3); else passes++;
        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int c0, n, kb0, st0, f0;
        bit ok;
        kb_times.delete();
        kb0 = kb_cnt;
        st0 = st_cnt;
        f0  = frames_rx;
        c0  = cyc;
        push_msg(4'b1011, n);
        wait_frames(f0 + 1, 60, ok);
        checks++; if (!ok) $display("[TB] FAIL single_timeout: got %0d frames, want %0d", frames_rx - f0, 1); else passes++;
        repeat (4) @(negedge clk);
        checks++; if (kb_cnt - kb0 != 1) $display("[TB] FAIL single_kb_count: got %0d, want 1", kb_cnt - kb0); else passes++;
        checks++; if (st_cnt - st0 != 1) $display("[TB] FAIL single_status_count: got %0d, want 1", st_cnt - st0); else passes++;
        checks++;
        if (kb_times.size() == 0) $display("[TB] FAIL single_latency: got no strobe, want cycle %0d", c0 + 2);
        else if (kb_times[0] != c0 + 2) $display("[TB] FAIL single_latency: got cycle %0d, want %0d", kb_times[0], c0 + 2);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n, f0;
        bit ok;
        logic [3:0] msgs [5] = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h3};
        kb_times.delete();
        f0 = frames_rx;
        push_msg(4'h6, n);
        for (int i = 0; i < 4; i++) push_msg(msgs[i], n);
        checks++; if (msg_ready !== 1'b0) $display("[TB] FAIL b2b_ready_drop: got %b, want 0", msg_ready); else passes++;
        push_msg(msgs[4], n);
        checks++; if (n == 0) $display("[TB] FAIL b2b_held: got wait %0d, want > 0", n); else passes++;
        wait_frames(f0 + 6, 200, ok);
        checks++; if (!ok) $display("[TB] FAIL b2b_timeout: got %0d frames, want 6", frames_rx - f0); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (kb_times.size() != 6) $display("[TB] FAIL b2b_strobes: got %0d, want 6", kb_times.size()); else passes++;
        for (int i = 0; i + 1 < kb_times.size(); i++) begin
            checks++;
            if (kb_times[i + 1] - kb_times[i] != 7) $display("[TB] FAIL b2b_period: got %0d, want 7", kb_times[i + 1] - kb_times[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_abort();
        int n;
        push_msg(4'hC, n);
        n = 0;
        while (!KBinit && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (KBinit !== 1'b1) $display("[TB] FAIL abort_start: got %b, want 1", KBinit); else passes++;
        mon_on = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (KBinit !== 1'b0) $display("[TB] FAIL abort_kbinit: got %b, want 0", KBinit); else passes++;
        checks++; if (serialOut !== 1'b0) $display("[TB] FAIL abort_serial: got %b, want 0", serialOut); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b, want 0", busy); else passes++;
        checks++; if (msg_ready !== 1'b1) $display("[TB] FAIL abort_ready: got %b, want 1", msg_ready); else passes++;
        checks++; if (int'(dut.u_fifo.count) != 0) $display("[TB] FAIL abort_fifo_empty: got %0d, want 0", dut.u_fifo.count); else passes++;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        mon_on = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (KBinit) n++;
        end
        checks++; if (n != 0) $display("[TB] FAIL abort_no_frame: got %0d strobes, want 0", n); else passes++;
    endtask

    task automatic test_full_pop();
        int n, f0;
        bit ok;
        f0 = frames_rx;
        push_msg(4'h1, n);
        push_msg(4'h2, n);
        push_msg(4'h4, n);
        push_msg(4'h8, n);
        push_msg(4'h7, n);
        checks++; if (msg_ready !== 1'b0) $display("[TB] FAIL full_ready: got %b, want 0", msg_ready); else passes++;
        msg_in    = 4'h9;
        msg_valid = 1'b1;
        n = 0;
        while (!msg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        msg_valid = 1'b0;
        checks++; if (msg_ready !== 1'b1) $display("[TB] FAIL full_pop_ready: got %b, want 1", msg_ready); else passes++;
        checks++; if (int'(dut.u_fifo.count) != 3) $display("[TB] FAIL full_pop_count: got %0d, want 3", dut.u_fifo.count); else passes++;
        wait_frames(f0 + 5, 200, ok);
        checks++; if (!ok) $display("[TB] FAIL full_timeout: got %0d frames, want 5", frames_rx - f0); else passes++;
        repeat (12) @(negedge clk);
        checks++; if (frames_rx - f0 != 5) $display("[TB] FAIL full_refused: got %0d frames, want 5", frames_rx - f0); else passes++;
    endtask

    task automatic test_random();
        int n, f0;
        bit ok;
        logic [3:0] d;
        f0 = frames_rx;
        for (int i = 0; i < 1000; i++) begin
            d = 4'($urandom_range(0, 15));
            push_msg(d, n);
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_frames(f0 + 1000, 3000, ok);
        checks++; if (!ok) $display("[TB] FAIL random_timeout: got %0d frames, want 1000", frames_rx - f0); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL random_leftover: got %0d, want 0", exp_q.size()); else passes++;
    endtask

    task automatic test_gap3();
        bit kb_tr [48];
        bit so_tr [48];
        bit st_tr [48];
        logic [3:0] exp3[$];
        logic [3:0] got, want;
        int k1, k2, cnt;
        checks++; if (msg_ready3 !== 1'b1) $display("[TB] FAIL gap3_ready: got %b, want 1", msg_ready3); else passes++;
        msg_in3 = 4'h9; msg_valid3 = 1'b1; exp3.push_back(4'h9);
        @(negedge clk);
        msg_in3 = 4'h6; exp3.push_back(4'h6);
        @(negedge clk);
        msg_valid3 = 1'b0;
        for (int i = 0; i < 48; i++) begin
            kb_tr[i] = kb3; so_tr[i] = so3; st_tr[i] = st3;
            @(negedge clk);
        end
        k1 = -1; k2 = -1;
        for (int i = 0; i < 48; i++) begin
            if (kb_tr[i] && k1 < 0) k1 = i;
            else if (kb_tr[i] && k1 >= 0 && k2 < 0) k2 = i;
        end
        checks++;
        if (k1 < 0 || k2 < 0 || k2 + 8 >= 48) $display("[TB] FAIL gap3_strobes: got %0d %0d, want two strobes", k1, k2);
        else begin
            passes++;
            checks++;
            if (k2 - (k1 + 4) - 1 != 4) $display("[TB] FAIL gap3_interval: got %0d, want 4", k2 - (k1 + 4) - 1); else passes++;
            for (int f = 0; f < 2; f++) begin
                int b = (f == 0) ? k1 : k2;
                got  = {so_tr[b + 1], so_tr[b + 2], so_tr[b + 3], so_tr[b + 4]};
                want = exp3.pop_front();
                checks++; if (got !== want) $display("[TB] FAIL gap3_data: got %h, want %h", got, want); else passes++;
            end
            cnt = 0;
            for (int i = k1 + 5; i <= k1 + 7; i++) if (so_tr[i]) cnt++;
            checks++; if (cnt != 0) $display("[TB] FAIL gap3_gap_bits: got %0d ones, want 0", cnt); else passes++;
            cnt = 0;
            for (int i = k1; i < k2; i++) if (st_tr[i]) cnt++;
            checks++; if (cnt != 1) $display("[TB] FAIL gap3_status_count: got %0d, want 1", cnt); else passes++;
            checks++; if (st_tr[k1 + 7] !== 1'b1) $display("[TB] FAIL gap3_status_pos: got %b, want 1", st_tr[k1 + 7]); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_abort();
        test_full_pop();
        test_random();
        test_gap3();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
